// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with storage, pointers, occupancy,
// almost-full/almost-empty status, sticky errors, flush and show-ahead/registered read.
//
// Parameters:
//   DATASIZE    word width
//   ADDRSIZE    address bits, DEPTH = 2**ADDRSIZE
//   FALLTHROUGH "TRUE" show-ahead read, "FALSE" registered read
//   AF_LEVEL    almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush              sync clear of pointers/count (wins over wr_en/rd_en)
//   wr_en, wdata       write request and data
//   rd_en, rdata       pop request and read data
//   full, empty        count == DEPTH / count == 0
//   almost_full/empty  threshold decodes of count
//   count              occupancy 0..DEPTH
//   overflow/underflow sticky error flags, cleared by clr_err
//   hwm                high-water mark (only with SYNC_FIFO_HWM_EN)
//
// Optional feature macro: SYNC_FIFO_HWM_EN

module sync_fifo_ctrl #(
  parameter int    DATASIZE    = 8,
  parameter int    ADDRSIZE    = 4,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    AF_LEVEL    = (2**ADDRSIZE) - 2,
  parameter int    AE_LEVEL    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rd_en,
  output logic [DATASIZE-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow,
`ifdef SYNC_FIFO_HWM_EN
  output logic [ADDRSIZE:0]   hwm,
`endif
  input  logic                clr_err
);

  localparam int DEPTH = 2**ADDRSIZE;
  localparam int CW    = ADDRSIZE + 1;

  localparam logic [ADDRSIZE:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDRSIZE:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [ADDRSIZE:0] AE_C    = CW'(AE_LEVEL);

  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_ctrl: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_ctrl: AE_LEVEL out of range 0..DEPTH-1");
    end
    if (FALLTHROUGH != "TRUE" && FALLTHROUGH != "FALSE") begin : g_bad_ft
      $error("sync_fifo_ctrl: FALLTHROUGH must be TRUE or FALSE");
    end
  endgenerate

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   count_q;
  logic [ADDRSIZE:0]   count_d;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE-1:0] raddr;
  logic                wa;
  logic                ra;
  logic                ovf_set;
  logic                udf_set;
  logic                unused_ptr_msb;

  assign waddr = wptr[ADDRSIZE-1:0];
  assign raddr = rptr[ADDRSIZE-1:0];

  // Pointer MSBs only carry lap information; occupancy comes from count_q.
  assign unused_ptr_msb = wptr[ADDRSIZE] ^ rptr[ADDRSIZE];

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // A full FIFO still takes a write when a read frees the head slot in
  // the same cycle; an empty FIFO never bypasses write data to a read.
  assign ra = rd_en && !empty && !flush;
  assign wa = wr_en && (!full || (rd_en && !empty)) && !flush;

  assign ovf_set = wr_en && !flush && full && !rd_en;
  assign udf_set = rd_en && !flush && empty;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({wa, ra})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wa) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wa) begin
          wptr <= wptr + 1'b1;
        end
        if (ra) begin
          rptr <= rptr + 1'b1;
        end
      end
    end
  end

  // A new error in the same cycle as clr_err must remain visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (udf_set) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FALLTHROUGH == "TRUE") begin : g_show_ahead
      assign rdata = mem[raddr];
    end else begin : g_reg_read
      logic [DATASIZE-1:0] rdata_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (ra) begin
          rdata_q <= mem[raddr];
        end
      end

      assign rdata = rdata_q;
    end
  endgenerate

`ifdef SYNC_FIFO_HWM_EN
  logic [ADDRSIZE:0] hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else if (clr_err) begin
      hwm_q <= count_q;
    end else if (count_q > hwm_q) begin
      hwm_q <= count_q;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule
